mult_req_sequencer: RTL and testbench
=====================================

MULT_REQ_SEQUENCER -- requirements
Module: mult_req_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning request FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter MULT_LAT, default 3, meaning cycles from mul_func high to a valid mul_out.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  upstream request present.
REQ-006 SHALL have port req_ready  output  1  request FIFO can accept.
REQ-007 SHALL have port req_a  input  2  multiplicand.
REQ-008 SHALL have port req_b  input  2  multiplier.
REQ-009 SHALL have port mul_func  output  1  start pulse to the two-bit multiplier core.
REQ-010 SHALL have port mul_in1  output  2  operand A to the core.
REQ-011 SHALL have port mul_in2  output  2  operand B to the core.
REQ-012 SHALL have port mul_out  input  4  product from the core.
REQ-013 SHALL have port rsp_valid  output  1  product held for downstream.
REQ-014 SHALL have port rsp_ready  input  1  downstream accepts product.
REQ-015 SHALL have port rsp_prod  output  4  captured product.
REQ-016 SHALL have port busy  output  1  high whenever the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-017 SHALL push {req_a,req_b} into the FIFO on a rising edge where req_valid && req_ready.
REQ-018 SHALL drive req_ready = !full, with no bypass path; a request offered while full SHALL NOT be accepted or lost, only stalled.
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-020 SHALL move from IDLE to ISSUE when the FIFO is non-empty; otherwise it SHALL stay in IDLE.
REQ-021 SHALL assert mul_func in ISSUE only, for exactly one cycle, then enter WAIT with a latency counter loaded to MULT_LAT-1.
REQ-022 SHALL drive mul_in1/mul_in2 from the FIFO head throughout ISSUE and WAIT, stable, and 0 in IDLE and RESP.
REQ-023 SHALL NOT assert mul_func outside ISSUE, so the core is never restarted mid-operation.
REQ-024 SHALL decrement the counter each WAIT cycle; in the WAIT cycle where the counter is 0, it SHALL register mul_out into rsp_prod, pop the FIFO head, and enter RESP.
REQ-025 SHALL hold rsp_valid high in RESP, with rsp_prod stable until the edge where rsp_ready is high.
REQ-026 On acceptance, SHALL go to ISSUE if the FIFO is non-empty, else to IDLE; rsp_valid SHALL drop in the next cycle.
REQ-027 SHALL give a latency of MULT_LAT+2 cycles from request acceptance into an empty, idle block to rsp_valid.
REQ-028 SHALL keep responses in request order; each accepted request SHALL yield exactly one response.
REQ-029 On a simultaneous push and pop (capture cycle), SHALL keep the FIFO count unchanged and the pointers wrapping modulo DEPTH.
REQ-030 SHALL keep FIFO accepts going during WAIT and RESP; rsp_ready low SHALL back-pressure to req_ready only via the FIFO filling.
REQ-031 SHALL treat products as unsigned; rsp_prod = req_a*req_b, range 0..9.

Reset
REQ-032 With rst high at an edge, SHALL go to FSM IDLE, empty the FIFO, counter 0, rsp_valid 0, rsp_prod 0, mul_func 0, mul_in1/mul_in2 0, req_ready 1 in the following cycle.
REQ-033 Reset mid-operation (ISSUE/WAIT/RESP) SHALL discard all queued and in-flight requests with no response emitted; the core SHALL share the same rst.

Structure
REQ-034 SHALL take the state enum, MULT_LAT default and the operand/product width constants from shared package mult_pkg.
REQ-035 SHALL implement the FIFO as sub-module mult_req_fifo (parameter DEPTH; push/pop/full/empty/head).

Verification
REQ-036 Single request: a=3, b=3 accepted at cycle 0 -> mul_func high cycle 1 only, rsp_valid cycle 5, rsp_prod=9.
REQ-037 Back-to-back: (2,3),(1,2),(3,1) with rsp_ready=1 -> products 6,2,3 in order, one mul_func per request, never during WAIT.
REQ-038 Back-pressure: rsp_ready=0 for 20 cycles with 4 requests offered -> req_ready low after DEPTH accepted plus one in RESP, none lost; release yields all in order.
REQ-039 Reset in WAIT: rst high one cycle -> next cycle rsp_valid=0, busy=0, req_ready=1; a subsequent request (2,2) returns 4.
REQ-040 Exhaustive: all 16 operand pairs with random rsp_ready -> each rsp_prod equals a*b; rsp_prod stable while rsp_valid && !rsp_ready.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the multiplier request sequencer
package mult_pkg;

    localparam int OP_W         = 2;
    localparam int PROD_W       = 2 * OP_W;
    localparam int MULT_LAT_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } req_t;

    // Latency counter width: must hold MULT_LAT-1, and never collapse to zero bits
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mult_req_fifo.sv
// rtl/mult_req_fifo.sv - power-of-two request FIFO with head peek
module mult_req_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt the count
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because empty gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mult_req_sequencer.sv
// rtl/mult_req_sequencer.sv - queues operand pairs and sequences them through a multi-cycle multiplier core
module mult_req_sequencer
    import mult_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_a,
    input  logic [OP_W-1:0]   req_b,
    output logic              mul_func,
    output logic [OP_W-1:0]   mul_in1,
    output logic [OP_W-1:0]   mul_in2,
    input  logic [PROD_W-1:0] mul_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PROD_W-1:0] rsp_prod,
    output logic              busy
);

    localparam int CNT_W = cnt_width(MULT_LAT);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               fifo_full;
    logic               fifo_empty;
    req_t               fifo_head;
    req_t               push_req;
    logic               push;
    logic               pop;

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign push_req  = '{a: req_a, b: req_b};
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    mult_req_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(req_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: one request at a time, the core is only restarted after the response leaves
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (cnt == '0) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nxt = fifo_empty ? ST_IDLE : ST_ISSUE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: operands are presented only while the core is working on them
    always_comb begin
        mul_func  = 1'b0;
        mul_in1   = '0;
        mul_in2   = '0;
        rsp_valid = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_ISSUE: begin
                mul_func = 1'b1;
                mul_in1  = fifo_head.a;
                mul_in2  = fifo_head.b;
            end
            ST_WAIT: begin
                mul_in1 = fifo_head.a;
                mul_in2 = fifo_head.b;
                pop     = (cnt == '0);
            end
            ST_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Latency counter and product capture; the head is popped on the same edge it is captured
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rsp_prod <= '0;
        end else begin
            if (state == ST_ISSUE)
                cnt <= CNT_W'(MULT_LAT - 1);
            else if (state == ST_WAIT && cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (pop)
                rsp_prod <= mul_out;
        end
    end

endmodule

// File: tb/tb_mult_req_sequencer.sv
// tb/tb_mult_req_sequencer.sv - self-checking bench for mult_req_sequencer
module tb_mult_req_sequencer;

    localparam int DEPTH    = 2;
    localparam int MULT_LAT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_a = 2'd0;
    logic [1:0] req_b = 2'd0;
    logic       mul_func;
    logic [1:0] mul_in1;
    logic [1:0] mul_in2;
    logic [3:0] mul_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_prod;
    logic       busy;

    mult_req_sequencer #(
        .DEPTH    (DEPTH),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_func  (mul_func),
        .mul_in1   (mul_in1),
        .mul_in2   (mul_in2),
        .mul_out   (mul_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Multiplier core: product is valid exactly MULT_LAT cycles after the start pulse, garbage otherwise
    logic       pv [MULT_LAT];
    logic [3:0] pp [MULT_LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MULT_LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= mul_func;
            pp[0] <= 4'(mul_in1) * 4'(mul_in2);
            for (int i = 1; i < MULT_LAT; i++) begin
                pv[i] <= pv[i-1];
                pp[i] <= pp[i-1];
            end
        end
    end
    assign mul_out = pv[MULT_LAT-1] ? pp[MULT_LAT-1] : 4'hF;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] pend[$];
    logic [3:0] acc_ops[$];
    int         exp_q[$];
    int         n_issued = 0;
    int         n_acc = 0;
    int         cyc = 0;
    int         last_func = 0;
    bit         have_last = 1'b0;
    logic [3:0] issue_ops = 4'h0;
    int         rdy_mode = 1;
    int         valid_pct = 100;
    bit         hold_valid = 1'b0;
    logic [3:0] hold_prod = 4'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, score the handshakes that will happen on the coming edge, advance
    task automatic cycle();
        bit         acc;
        bit         dq;
        logic [3:0] ops;
        ops       = (pend.size() > 0) ? pend[0] : 4'h0;
        req_valid = (pend.size() > 0) && ($urandom_range(99) < valid_pct);
        req_a     = ops[3:2];
        req_b     = ops[1:0];
        case (rdy_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(1));
        endcase
        acc = req_valid && req_ready;
        dq  = rsp_valid && rsp_ready;
        if (!rst) begin
            if (hold_valid) begin
                chk("hold_valid", rsp_valid, 1);
                chk("hold_prod", rsp_prod, hold_prod);
            end
            if (dq) begin
                if (exp_q.size() > 0) chk("rsp_prod", rsp_prod, exp_q.pop_front());
                else                  chk("spurious_rsp", rsp_valid, 0);
            end
            if (mul_func) begin
                if (have_last) chk("func_gap", (cyc - last_func) >= MULT_LAT + 2, 1);
                if (n_issued < acc_ops.size()) chk("mul_ops", {mul_in1, mul_in2}, acc_ops[n_issued]);
                else                           chk("func_no_req", mul_func, 0);
                issue_ops = {mul_in1, mul_in2};
                last_func = cyc;
                have_last = 1'b1;
                n_issued++;
            end else if (have_last && (cyc - last_func) <= MULT_LAT) begin
                chk("ops_stable", {mul_in1, mul_in2}, issue_ops);
            end
        end
        hold_valid = rsp_valid && !rsp_ready && !rst;
        hold_prod  = rsp_prod;
        @(posedge clk);
        #1;
        cyc++;
        if (acc && !rst) begin
            void'(pend.pop_front());
            acc_ops.push_back(ops);
            exp_q.push_back(int'(ops[3:2]) * int'(ops[1:0]));
            n_acc++;
        end
    endtask

    task automatic clear_model();
        pend.delete();
        acc_ops.delete();
        exp_q.delete();
        n_issued   = 0;
        have_last  = 1'b0;
        hold_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", pend.size() + exp_q.size(), 0);
    endtask

    task automatic check_idle_after_reset();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mul_func", mul_func, 0);
        chk("rst_mul_in1", mul_in1, 0);
        chk("rst_mul_in2", mul_in2, 0);
        chk("rst_rsp_prod", rsp_prod, 0);
    endtask

    initial begin
        int f0;
        int a0;
        int n;

        // Reset state
        clear_model();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        check_idle_after_reset();

        // Single request 3*3: start pulse one cycle after acceptance, response MULT_LAT+2 after
        rdy_mode  = 0;
        valid_pct = 100;
        pend.push_back({2'd3, 2'd3});
        cycle();
        for (int k = 0; k <= MULT_LAT + 2; k++) begin
            chk("single_mul_func", mul_func, (k == 1));
            chk("single_rsp_valid", rsp_valid, (k == MULT_LAT + 2));
            if (k < MULT_LAT + 2) cycle();
        end
        chk("single_prod", rsp_prod, 9);
        rdy_mode = 1;
        cycle();
        chk("single_drop_valid", rsp_valid, 0);
        chk("single_idle", busy, 0);

        // Back-to-back requests with downstream always ready
        f0 = n_issued;
        pend.push_back({2'd2, 2'd3});
        pend.push_back({2'd1, 2'd2});
        pend.push_back({2'd3, 2'd1});
        drain(200);
        chk("b2b_func_count", n_issued - f0, 3);

        // Back-pressure: FIFO fills plus one parked in the response slot
        rdy_mode = 0;
        a0 = n_acc;
        for (int i = 0; i < 4; i++) pend.push_back(4'($urandom_range(15)));
        repeat (20) cycle();
        chk("bp_accepted", n_acc - a0, DEPTH + 1);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        rdy_mode = 1;
        drain(300);
        chk("bp_all_accepted", n_acc - a0, 4);

        // Reset while the core is working
        pend.push_back({2'd1, 2'd3});
        pend.push_back({2'd3, 2'd2});
        n = 0;
        while (!mul_func && n < 20) begin
            cycle();
            n++;
        end
        chk("reach_issue", mul_func, 1);
        cycle();
        clear_model();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("wrst_rsp_valid", rsp_valid, 0);
        chk("wrst_busy", busy, 0);
        chk("wrst_req_ready", req_ready, 1);
        repeat (10) cycle();
        chk("wrst_no_func", n_issued, 0);
        pend.push_back({2'd2, 2'd2});
        drain(100);

        // All operand pairs with random gaps and random downstream stalls
        rdy_mode  = 2;
        valid_pct = 70;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                pend.push_back({2'(a), 2'(b)});
        drain(3000);
        chk("exh_issue_count", n_issued, acc_ops.size());
        chk("exh_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
